// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: default bus width plus byte-valid counting and
// count-to-keep decoding used by the header inserter and the byte packer.
package axis_pkg;

  localparam int unsigned AXIS_DATA_WD   = 32;
  localparam int unsigned AXIS_MAX_BYTES = 64;

  // Number of set keep bits; callers zero-extend narrower keep vectors.
  function automatic int unsigned popcount_keep(input logic [AXIS_MAX_BYTES-1:0] keep);
    int unsigned c;
    c = 0;
    for (int i = 0; i < AXIS_MAX_BYTES; i++) begin
      c += 32'(keep[i]);
    end
    return c;
  endfunction

  // MSB-aligned keep for an n-byte beat holding cnt valid bytes (saturates at n).
  function automatic logic [AXIS_MAX_BYTES-1:0] keep_from_cnt(input int unsigned cnt,
                                                              input int unsigned n);
    logic [AXIS_MAX_BYTES-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < AXIS_MAX_BYTES; i++) begin
      if ((i < n) && ((i + cnt) >= n)) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/axis_byte_compact.sv
// Left-packs the kept bytes of one beat: slot 0 receives the highest-index kept
// byte (first on the wire); unused slots are driven to zero.
module axis_byte_compact
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WD      = AXIS_DATA_WD,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  output logic [DATA_WD-1:0]      comp_data,
  output logic [BYTE_CNT_WD:0]    comp_cnt
);

  localparam int unsigned K_WD = BYTE_CNT_WD + 1;

  // Each kept byte lands at the slot given by the count of kept bytes above it.
  always_comb begin
    int unsigned pos;
    comp_data = '0;
    pos       = 0;
    for (int i = DATA_BYTE_WD - 1; i >= 0; i--) begin
      for (int unsigned s = 0; s < DATA_BYTE_WD; s++) begin
        if (keep_in[i] && (pos == s)) comp_data[8*s +: 8] = data_in[8*i +: 8];
      end
      pos += 32'(keep_in[i]);
    end
    comp_cnt = K_WD'(popcount_keep(AXIS_MAX_BYTES'(keep_in)));
  end

endmodule

// File: rtl/axi_stream_byte_packer.sv
// Repacks a sparse-keep AXI-Stream into dense, MSB-aligned beats while keeping
// byte order and packet boundaries; dense input streams at one beat per cycle.
module axi_stream_byte_packer
  import axis_pkg::*;
#(
  parameter int unsigned DATA_WD      = AXIS_DATA_WD,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  localparam int unsigned N         = DATA_BYTE_WD;
  localparam int unsigned BUF_BYTES = 2 * N - 1;
  localparam int unsigned BUF_WD    = 8 * BUF_BYTES;
  localparam int unsigned CNT_WD    = $clog2(2 * N);

  // Slot j of the buffer sits at bits [8*j +: 8]; slot 0 is the oldest byte.
  // Bytes at or above cnt_q are always zero, so appends can simply OR in.
  logic [BUF_WD-1:0]      buf_q, buf_d, shifted, appended;
  logic [CNT_WD-1:0]      cnt_q, cnt_d, cnt_after_out, take;
  logic                   last_pending_q, last_pending_d;
  logic                   full_c, out_fire, in_fire;
  logic [DATA_WD-1:0]     comp_data;
  logic [BYTE_CNT_WD:0]   comp_cnt;

  axis_byte_compact #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_compact (
    .data_in   (data_in),
    .keep_in   (keep_in),
    .comp_data (comp_data),
    .comp_cnt  (comp_cnt)
  );

  // Handshake: the output drains first, so a firing output can re-open ready_in.
  always_comb begin
    full_c        = cnt_q >= CNT_WD'(N);
    valid_out     = full_c | last_pending_q;
    last_out      = last_pending_q & (cnt_q <= CNT_WD'(N));
    out_fire      = valid_out & ready_out;
    take          = '0;
    if (out_fire) take = full_c ? CNT_WD'(N) : cnt_q;
    cnt_after_out = cnt_q - take;
    ready_in      = !rst && !last_pending_q && (cnt_after_out < CNT_WD'(N));
    in_fire       = valid_in & ready_in;
  end

  // Shift out the emitted bytes, then append the compacted beat behind the rest.
  always_comb begin
    shifted        = buf_q >> (8 * take);
    appended       = BUF_WD'(comp_data) << (8 * cnt_after_out);
    buf_d          = shifted;
    cnt_d          = cnt_after_out;
    last_pending_d = last_pending_q;
    if (out_fire && last_out) last_pending_d = 1'b0;
    if (in_fire) begin
      buf_d          = shifted | appended;
      cnt_d          = cnt_after_out + CNT_WD'(comp_cnt);
      last_pending_d = last_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q          <= '0;
      cnt_q          <= '0;
      last_pending_q <= 1'b0;
    end else begin
      buf_q          <= buf_d;
      cnt_q          <= cnt_d;
      last_pending_q <= last_pending_d;
    end
  end

  // Oldest byte goes to the most significant lane.
  for (genvar j = 0; j < N; j++) begin : g_out_lane
    assign data_out[8*(N-1-j) +: 8] = buf_q[8*j +: 8];
  end

  assign keep_out = N'(keep_from_cnt(32'(cnt_q), N));

endmodule

// File: tb/tb_axi_stream_byte_packer.sv
// Directed bench for axi_stream_byte_packer with N = 4 byte lanes.
module tb_axi_stream_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    int          cyc;
  } beat_t;

  beat_t oq[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;

  axi_stream_byte_packer #(.DATA_WD(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .keep_in   (keep_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .keep_out  (keep_out),
    .last_out  (last_out),
    .ready_out (ready_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Capture every output handshake mid-cycle, after inputs have settled.
  always @(negedge clk) begin
    if (valid_out && ready_out)
      oq.push_back('{d: data_out, k: keep_out, l: last_out, cyc: cyc});
  end

  // Present one beat and hold it until accepted (bounded); leaves us at posedge+1.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                      output int waits);
    bit done;
    done     = 1'b0;
    waits    = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (ready_in) done = 1'b1;
      else waits++;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    data_in  = '0;
    keep_in  = '0;
    last_in  = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL send_timeout data=%h keep=%b not accepted within 50 cycles", d, k);
    end
  endtask

  task automatic drain(input int n);
    for (int c = 0; c < 60 && oq.size() < n; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    valid_in  = 1'b0;
    data_in   = '0;
    keep_in   = '0;
    last_in   = 1'b0;
    ready_out = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({valid_out, last_out, ready_in, data_out, keep_out} !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got v=%b l=%b rdy=%b d=%h k=%b, want all zero",
               valid_out, last_out, ready_in, data_out, keep_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready_in !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got %b want 1", ready_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_header_payload;
    logic [31:0] ed [2] = '{32'hA1A2B1B2, 32'hB3B4C1C2};
    logic        el [2] = '{1'b0, 1'b1};
    int w;
    oq.delete();
    ready_out = 1'b1;
    send(32'h5A5AA1A2, 4'b0011, 1'b0, w);
    send(32'hB1B2B3B4, 4'b1111, 1'b0, w);
    send(32'hC1C25A5A, 4'b1100, 1'b1, w);
    drain(2);
    vectors++;
    if (oq.size() != 2) begin
      miscompares++;
      $display("FAIL hdr_count got %0d beats want 2", oq.size());
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (i >= oq.size()) begin
        miscompares++;
        $display("FAIL hdr_beat%0d missing, want d=%h", i, ed[i]);
      end else if ({oq[i].d, oq[i].k, oq[i].l} !== {ed[i], 4'b1111, el[i]}) begin
        miscompares++;
        $display("FAIL hdr_beat%0d got d=%h k=%b l=%b want d=%h k=1111 l=%b",
                 i, oq[i].d, oq[i].k, oq[i].l, ed[i], el[i]);
      end
    end
  endtask

  task automatic test_dense;
    int w;
    oq.delete();
    ready_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(32'h01020304 + 32'(i) * 32'h10101010, 4'b1111, 1'(i == 7), w);
      vectors++;
      if (w != 0) begin
        miscompares++;
        $display("FAIL dense_ready_drop beat%0d waited %0d cycles want 0", i, w);
      end
    end
    drain(8);
    vectors++;
    if (oq.size() != 8) begin
      miscompares++;
      $display("FAIL dense_count got %0d beats want 8", oq.size());
    end
    for (int i = 0; i < 8 && i < oq.size(); i++) begin
      vectors++;
      if ({oq[i].d, oq[i].k, oq[i].l} !==
          {32'h01020304 + 32'(i) * 32'h10101010, 4'b1111, 1'(i == 7)}) begin
        miscompares++;
        $display("FAIL dense_beat%0d got d=%h k=%b l=%b want d=%h k=1111 l=%b",
                 i, oq[i].d, oq[i].k, oq[i].l, 32'h01020304 + 32'(i) * 32'h10101010, i == 7);
      end
      if (i > 0) begin
        vectors++;
        if (oq[i].cyc != oq[i-1].cyc + 1) begin
          miscompares++;
          $display("FAIL dense_rate beat%0d at cycle %0d want %0d", i, oq[i].cyc, oq[i-1].cyc + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] ed [3] = '{32'hC0C1C2C3, 32'hC4C5C6C7, 32'hC8C9CACB};
    int w;
    oq.delete();
    ready_out = 1'b0;
    send(ed[0], 4'b1111, 1'b0, w);
    valid_in = 1'b1;
    data_in  = ed[1];
    keep_in  = 4'b1111;
    last_in  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({valid_out, data_out, keep_out, last_out, ready_in} !== {1'b1, ed[0], 4'b1111, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_c%0d got v=%b d=%h k=%b l=%b rdy=%b want v=1 d=%h k=1111 l=0 rdy=0",
                 c, valid_out, data_out, keep_out, last_out, ready_in, ed[0]);
      end
      @(posedge clk);
      #1;
    end
    ready_out = 1'b1;
    send(ed[1], 4'b1111, 1'b0, w);
    send(ed[2], 4'b1111, 1'b1, w);
    drain(3);
    vectors++;
    if (oq.size() != 3) begin
      miscompares++;
      $display("FAIL bp_count got %0d beats want 3", oq.size());
    end
    for (int i = 0; i < 3 && i < oq.size(); i++) begin
      vectors++;
      if ({oq[i].d, oq[i].k, oq[i].l} !== {ed[i], 4'b1111, 1'(i == 2)}) begin
        miscompares++;
        $display("FAIL bp_beat%0d got d=%h k=%b l=%b want d=%h k=1111 l=%b",
                 i, oq[i].d, oq[i].k, oq[i].l, ed[i], i == 2);
      end
    end
  endtask

  task automatic test_sparse_tail;
    logic [31:0] ed [3] = '{32'hD0D1E0E1, 32'hE2E3F0F1, 32'hF2000000};
    logic [3:0]  ek [3] = '{4'b1111, 4'b1111, 4'b1000};
    logic        el [3] = '{1'b0, 1'b0, 1'b1};
    int w;
    oq.delete();
    ready_out = 1'b1;
    send(32'hD05AD15A, 4'b1010, 1'b0, w);
    send(32'hE0E1E2E3, 4'b1111, 1'b0, w);
    send(32'h5AF0F1F2, 4'b0111, 1'b1, w);
    drain(3);
    vectors++;
    if (oq.size() != 3) begin
      miscompares++;
      $display("FAIL sparse_count got %0d beats want 3", oq.size());
    end
    for (int i = 0; i < 3 && i < oq.size(); i++) begin
      vectors++;
      if ({oq[i].d, oq[i].k, oq[i].l} !== {ed[i], ek[i], el[i]}) begin
        miscompares++;
        $display("FAIL sparse_beat%0d got d=%h k=%b l=%b want d=%h k=%b l=%b",
                 i, oq[i].d, oq[i].k, oq[i].l, ed[i], ek[i], el[i]);
      end
    end
  endtask

  task automatic test_empty_packet;
    int w;
    oq.delete();
    ready_out = 1'b1;
    send(32'hDEADBEEF, 4'b0000, 1'b1, w);
    drain(1);
    vectors++;
    if (oq.size() != 1) begin
      miscompares++;
      $display("FAIL empty_count got %0d beats want 1", oq.size());
    end else begin
      vectors++;
      if ({oq[0].d, oq[0].k, oq[0].l} !== {32'h0, 4'b0000, 1'b1}) begin
        miscompares++;
        $display("FAIL empty_beat got d=%h k=%b l=%b want d=00000000 k=0000 l=1",
                 oq[0].d, oq[0].k, oq[0].l);
      end
    end
  endtask

  task automatic test_reset_mid_packet;
    int w;
    oq.delete();
    ready_out = 1'b0;
    send(32'h5A5A1112, 4'b0011, 1'b0, w);
    send(32'h5A131415, 4'b0111, 1'b0, w);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({valid_out, last_out, ready_in, data_out, keep_out} !== 39'd0) begin
      miscompares++;
      $display("FAIL midrst_outputs got v=%b l=%b rdy=%b d=%h k=%b, want all zero",
               valid_out, last_out, ready_in, data_out, keep_out);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ready_out = 1'b1;
    send(32'hA1A2A3A4, 4'b1111, 1'b1, w);
    drain(1);
    vectors++;
    if (oq.size() != 1) begin
      miscompares++;
      $display("FAIL midrst_count got %0d beats want 1", oq.size());
    end else begin
      vectors++;
      if ({oq[0].d, oq[0].k, oq[0].l} !== {32'hA1A2A3A4, 4'b1111, 1'b1}) begin
        miscompares++;
        $display("FAIL midrst_beat got d=%h k=%b l=%b want d=a1a2a3a4 k=1111 l=1",
                 oq[0].d, oq[0].k, oq[0].l);
      end
    end
  endtask

  initial begin
    test_reset();
    test_header_payload();
    test_dense();
    test_backpressure();
    test_sparse_tail();
    test_empty_packet();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
